usb_txn_engine: RTL and testbench

USB_TXN_ENGINE -- requirements
Module: usb_txn_engine

---
 rtl/usb_txn_engine.sv | 242 ++++++++++++++++++++++++
 tb/tb_usb_txn_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_txn_engine.sv
// USB host transaction engine: token/data/handshake sequencing with per-endpoint data toggles and retries.
// Latency: one FSM step per clk; tx packet fields are registered state, decoded combinationally per state.
// Backpressure: holds tx_* stable until tx_ready, holds rsp_* until rsp_ready, req_ready only in IDLE.
module usb_txn_engine #(
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 256,
    parameter int MAX_TRY     = 8,
    parameter int NUM_EP      = 16
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_dir,
    input  logic [6:0]        req_addr,
    input  logic [3:0]        req_endp,
    input  logic [DATA_W-1:0] req_data,
    input  logic              toggle_clr,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [3:0]        tx_pid,
    output logic              tx_has_data,
    output logic [6:0]        tx_addr,
    output logic [3:0]        tx_endp,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_busy,
    input  logic              rx_valid,
    input  logic [3:0]        rx_pid,
    input  logic              rx_crc_err,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_ok,
    output logic [DATA_W-1:0] rsp_data
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    TRY_LAST = 4'(MAX_TRY - 1);
    localparam logic [15:0]   EP_MASK  = 16'((32'h1 << NUM_EP) - 32'h1);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [2:0] {IDLE, TOK, DTX, WHS, WDATA, HTX, RSP} state_t;

    state_t            state_q, state_d;
    logic              dir_q;
    logic [6:0]        addr_q;
    logic [3:0]        endp_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        try_q, try_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [15:0]       tog_q;
    logic              dtx_tog_q, dtx_tog_d;
    logic              hs_nak_q, hs_nak_d;
    logic              good_q, good_d;
    logic              rsp_ok_q, rsp_ok_d;
    logic [DATA_W-1:0] rsp_data_q;
    logic              capture, load_data, flip, retry, tog_cur;

    assign tog_cur  = tog_q[endp_q];
    assign rsp_ok   = rsp_ok_q;
    assign rsp_data = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        try_d       = try_q;
        timer_d     = timer_q;
        dtx_tog_d   = dtx_tog_q;
        hs_nak_d    = hs_nak_q;
        good_d      = good_q;
        rsp_ok_d    = rsp_ok_q;
        capture     = 1'b0;
        load_data   = 1'b0;
        flip        = 1'b0;
        retry       = 1'b0;
        req_ready   = 1'b0;
        tx_valid    = 1'b0;
        tx_pid      = 4'b0000;
        tx_has_data = 1'b0;
        tx_addr     = 7'd0;
        tx_endp     = 4'd0;
        tx_data     = '0;
        rsp_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    capture = 1'b1;
                    try_d   = 4'd0;
                    state_d = TOK;
                end
            end
            TOK: begin
                tx_valid = 1'b1;
                tx_pid   = dir_q ? PID_IN : PID_OUT;
                tx_addr  = addr_q;
                tx_endp  = endp_q;
                if (tx_ready) begin
                    timer_d   = '0;
                    // Latch the DATA PID so it cannot move under a stalled DTX.
                    dtx_tog_d = tog_cur & ~toggle_clr;
                    state_d   = dir_q ? WDATA : DTX;
                end
            end
            DTX: begin
                tx_valid    = 1'b1;
                tx_has_data = 1'b1;
                tx_pid      = dtx_tog_q ? PID_DATA1 : PID_DATA0;
                tx_addr     = addr_q;
                tx_endp     = endp_q;
                tx_data     = data_q;
                if (tx_ready) begin
                    timer_d = '0;
                    state_d = WHS;
                end
            end
            WHS: begin
                if (rx_valid) begin
                    if (!rx_crc_err && rx_pid == PID_ACK) begin
                        flip     = 1'b1;
                        rsp_ok_d = 1'b1;
                        state_d  = RSP;
                    end else begin
                        retry = 1'b1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    retry = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WDATA: begin
                if (rx_valid) begin
                    if (rx_crc_err) begin
                        hs_nak_d = 1'b1;
                        good_d   = 1'b0;
                        state_d  = HTX;
                    end else if (rx_pid == PID_DATA0 || rx_pid == PID_DATA1) begin
                        // A stale toggle is still ACKed so the device advances, but its data is dropped.
                        hs_nak_d = 1'b0;
                        state_d  = HTX;
                        if ((rx_pid == PID_DATA1) == tog_cur) begin
                            load_data = 1'b1;
                            flip      = 1'b1;
                            good_d    = 1'b1;
                        end else begin
                            good_d = 1'b0;
                        end
                    end else begin
                        retry = 1'b1;
                    end
                end else if (!rx_busy) begin
                    if (timer_q == TMO_LAST) begin
                        retry = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            HTX: begin
                tx_valid = 1'b1;
                tx_pid   = hs_nak_q ? PID_NAK : PID_ACK;
                tx_addr  = addr_q;
                tx_endp  = endp_q;
                if (tx_ready) begin
                    if (good_q) begin
                        rsp_ok_d = 1'b1;
                        state_d  = RSP;
                    end else begin
                        retry = 1'b1;
                    end
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (retry) begin
            if (try_q == TRY_LAST) begin
                rsp_ok_d = 1'b0;
                state_d  = RSP;
            end else begin
                try_d   = try_q + 4'd1;
                timer_d = '0;
                state_d = TOK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            addr_q     <= 7'd0;
            endp_q     <= 4'd0;
            data_q     <= '0;
            try_q      <= 4'd0;
            timer_q    <= '0;
            tog_q      <= 16'd0;
            dtx_tog_q  <= 1'b0;
            hs_nak_q   <= 1'b0;
            good_q     <= 1'b0;
            rsp_ok_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q   <= state_d;
            try_q     <= try_d;
            timer_q   <= timer_d;
            dtx_tog_q <= dtx_tog_d;
            hs_nak_q  <= hs_nak_d;
            good_q    <= good_d;
            rsp_ok_q  <= rsp_ok_d;
            if (capture) begin
                dir_q  <= req_dir;
                addr_q <= req_addr;
                endp_q <= req_endp;
                data_q <= req_data;
            end
            if (load_data) begin
                rsp_data_q <= rx_data;
            end
            if (toggle_clr) begin
                tog_q <= 16'd0;
            end else if (flip) begin
                tog_q <= (tog_q ^ (16'h1 << endp_q)) & EP_MASK;
            end
        end
    end

endmodule

// File: tb/tb_usb_txn_engine.sv
// Directed bench for usb_txn_engine with tx/rsp scoreboards fed from the stimulus sequence.
module tb_usb_txn_engine;

    localparam int TMO = 256;
    localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_ACK = 4'b0010, P_NAK = 4'b1010;

    logic        clk = 1'b0;
    logic        rst_L;
    logic        req_valid, req_ready, req_dir;
    logic [6:0]  req_addr;
    logic [3:0]  req_endp;
    logic [63:0] req_data;
    logic        toggle_clr;
    logic        tx_valid, tx_ready, tx_has_data;
    logic [3:0]  tx_pid, tx_endp;
    logic [6:0]  tx_addr;
    logic [63:0] tx_data;
    logic        rx_busy, rx_valid, rx_crc_err;
    logic [3:0]  rx_pid;
    logic [63:0] rx_data;
    logic        rsp_valid, rsp_ready, rsp_ok;
    logic [63:0] rsp_data;

    usb_txn_engine dut (
        .clk(clk), .rst_L(rst_L),
        .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
        .req_addr(req_addr), .req_endp(req_endp), .req_data(req_data),
        .toggle_clr(toggle_clr),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_pid(tx_pid), .tx_has_data(tx_has_data),
        .tx_addr(tx_addr), .tx_endp(tx_endp), .tx_data(tx_data),
        .rx_busy(rx_busy), .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_crc_err(rx_crc_err),
        .rx_data(rx_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pid;
        logic        has_data;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] data;
    } exp_tx_t;
    typedef struct {
        logic        ok;
        logic [63:0] data;
    } exp_rsp_t;

    exp_tx_t  exp_tx[$];
    exp_rsp_t exp_rsp[$];
    int checks = 0, failures = 0;
    int tx_hs_cnt = 0, rsp_hs_cnt = 0, tx_pushed = 0, rsp_pushed = 0;
    int idle_run = 0;
    bit chk_gap = 0, stall = 0;
    logic [3:0]  last_pid = 4'd0, st_pid;
    logic [63:0] st_data;
    logic [15:0] mtog = 16'd0;
    logic [63:0] m_rsp = 64'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dpid(input logic t);
        return t ? 4'b1011 : 4'b0011;
    endfunction

    task automatic push_tx(input logic [3:0] pid, input logic hd, input logic [6:0] a,
                           input logic [3:0] e, input logic [63:0] d);
        exp_tx_t x;
        x.pid = pid; x.has_data = hd; x.addr = a; x.endp = e; x.data = d;
        exp_tx.push_back(x);
        tx_pushed++;
    endtask

    task automatic push_rsp(input logic ok, input logic [63:0] d);
        exp_rsp_t r;
        r.ok = ok; r.data = d;
        exp_rsp.push_back(r);
        rsp_pushed++;
    endtask

    task automatic send_req(input logic dir, input logic [6:0] a, input logic [3:0] e, input logic [63:0] d);
        req_valid = 1'b1; req_dir = dir; req_addr = a; req_endp = e; req_data = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [3:0] pid, input logic crc, input logic [63:0] d);
        rx_valid = 1'b1; rx_pid = pid; rx_crc_err = crc; rx_data = d;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_crc_err = 1'b0;
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n = 0;
        while (tx_hs_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (tx_hs_cnt < target) check("wait_tx_timeout", tx_hs_cnt, target);
        #1;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n = 0;
        while (rsp_hs_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (rsp_hs_cnt < target) check("wait_rsp_timeout", rsp_hs_cnt, target);
        #1;
    endtask

    // Handshakes are sampled on the falling edge, one half-cycle before the edge that completes them.
    always @(negedge clk) begin
        if (!rst_L) begin
            stall    = 0;
            idle_run = 0;
        end else begin
            if (stall && tx_valid) begin
                check("tx_stable_pid", tx_pid, st_pid);
                check("tx_stable_data", tx_data, st_data);
            end
            if (tx_valid && tx_ready) begin
                tx_hs_cnt++;
                if (exp_tx.size() == 0) begin
                    check("tx_extra", tx_hs_cnt, tx_pushed);
                end else begin
                    exp_tx_t e;
                    e = exp_tx.pop_front();
                    check("tx_pid", tx_pid, e.pid);
                    check("tx_has_data", tx_has_data, e.has_data);
                    if (e.pid == P_OUT || e.pid == P_IN) begin
                        check("tx_addr", tx_addr, e.addr);
                        check("tx_endp", tx_endp, e.endp);
                    end
                    if (e.has_data) check("tx_data", tx_data, e.data);
                    if (chk_gap && tx_pid == P_OUT && last_pid == 4'b0011)
                        check("timeout_gap", idle_run, TMO);
                end
                last_pid = tx_pid;
                idle_run = 0;
                stall    = 0;
            end else if (tx_valid) begin
                stall   = 1;
                st_pid  = tx_pid;
                st_data = tx_data;
            end else begin
                stall = 0;
                idle_run++;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_hs_cnt++;
                if (exp_rsp.size() == 0) begin
                    check("rsp_extra", rsp_hs_cnt, rsp_pushed);
                end else begin
                    exp_rsp_t r;
                    r = exp_rsp.pop_front();
                    check("rsp_ok", rsp_ok, r.ok);
                    check("rsp_data", rsp_data, r.data);
                end
            end
        end
    end

    initial begin
        rst_L = 1'b0; req_valid = 1'b0; req_dir = 1'b0; req_addr = 7'd0; req_endp = 4'd0;
        req_data = 64'd0; toggle_clr = 1'b0; tx_ready = 1'b1; rx_busy = 1'b0; rx_valid = 1'b0;
        rx_pid = 4'd0; rx_crc_err = 1'b0; rx_data = 64'd0; rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_ok", rsp_ok, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_tx_pid", tx_pid, 4'd0);
        check("rst_tx_data", tx_data, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        @(posedge clk); #1 rst_L = 1'b1;
        @(posedge clk); #1;

        // OUT with a stalled token, ACK after 5 cycles; then a second OUT must use DATA1.
        tx_ready = 1'b0;
        push_tx(P_OUT, 0, 7, 3, 0);
        push_tx(dpid(mtog[3]), 1, 7, 3, 64'hAABBCCDD);
        push_rsp(1, m_rsp);
        send_req(0, 7, 3, 64'hAABBCCDD);
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_tx(2, 50);
        repeat (5) @(posedge clk);
        #1 send_rx(P_ACK, 0, 0);
        mtog[3] = ~mtog[3];
        wait_rsp(1, 50);
        push_tx(P_OUT, 0, 7, 3, 0);
        push_tx(dpid(mtog[3]), 1, 7, 3, 64'h11);
        push_rsp(1, m_rsp);
        send_req(0, 7, 3, 64'h11);
        wait_tx(4, 50);
        send_rx(P_ACK, 0, 0);
        mtog[3] = ~mtog[3];
        wait_rsp(2, 50);

        // IN on endp 2 with a good DATA0.
        push_tx(P_IN, 0, 5, 2, 0);
        push_tx(P_ACK, 0, 5, 2, 0);
        m_rsp = 64'h1234;
        push_rsp(1, m_rsp);
        send_req(1, 5, 2, 0);
        wait_tx(5, 50);
        repeat (3) @(posedge clk);
        #1 send_rx(dpid(mtog[2]), 0, 64'h1234);
        mtog[2] = ~mtog[2];
        wait_tx(6, 50);
        wait_rsp(3, 50);

        // OUT never answered: eight OUT+DATA0 pairs, then failure with rsp_data untouched.
        chk_gap = 1;
        for (int i = 0; i < 8; i++) begin
            push_tx(P_OUT, 0, 9, 4, 0);
            push_tx(dpid(mtog[4]), 1, 9, 4, 64'h55);
        end
        push_rsp(0, m_rsp);
        send_req(0, 9, 4, 64'h55);
        wait_tx(22, 3000);
        wait_rsp(4, 400);
        chk_gap = 0;
        push_tx(P_OUT, 0, 9, 4, 0);
        push_tx(dpid(mtog[4]), 1, 9, 4, 64'h66);
        push_rsp(1, m_rsp);
        send_req(0, 9, 4, 64'h66);
        wait_tx(24, 50);
        send_rx(P_ACK, 0, 0);
        mtog[4] = ~mtog[4];
        wait_rsp(5, 50);

        // IN: long rx_busy must not time out; CRC error draws NAK, then retry succeeds.
        push_tx(P_IN, 0, 2, 5, 0);
        push_tx(P_NAK, 0, 2, 5, 0);
        push_tx(P_IN, 0, 2, 5, 0);
        push_tx(P_ACK, 0, 2, 5, 0);
        m_rsp = 64'h5678;
        push_rsp(1, m_rsp);
        send_req(1, 2, 5, 0);
        wait_tx(25, 50);
        rx_busy = 1'b1;
        repeat (400) @(posedge clk);
        #1 check("busy_freeze", tx_hs_cnt, 25);
        rx_busy = 1'b0;
        send_rx(dpid(mtog[5]), 1, 64'hDEAD);
        wait_tx(27, 50);
        send_rx(dpid(mtog[5]), 0, 64'h5678);
        mtog[5] = ~mtog[5];
        wait_tx(28, 50);
        wait_rsp(6, 50);

        // IN receives the wrong toggle: ACKed, dropped, token re-sent.
        push_tx(P_IN, 0, 3, 6, 0);
        push_tx(P_ACK, 0, 3, 6, 0);
        push_tx(P_IN, 0, 3, 6, 0);
        push_tx(P_ACK, 0, 3, 6, 0);
        push_rsp(1, 64'h9ABC);
        send_req(1, 3, 6, 0);
        wait_tx(29, 50);
        send_rx(dpid(~mtog[6]), 0, 64'hBAD);
        wait_tx(30, 50);
        check("stale_discard", rsp_data, m_rsp);
        m_rsp = 64'h9ABC;
        wait_tx(31, 50);
        send_rx(dpid(mtog[6]), 0, 64'h9ABC);
        mtog[6] = ~mtog[6];
        wait_tx(32, 50);
        wait_rsp(7, 50);

        // Response backpressure.
        rsp_ready = 1'b0;
        push_tx(P_OUT, 0, 1, 3, 0);
        push_tx(dpid(mtog[3]), 1, 1, 3, 64'h77);
        push_rsp(1, m_rsp);
        send_req(0, 1, 3, 64'h77);
        wait_tx(34, 50);
        send_rx(P_ACK, 0, 0);
        mtog[3] = ~mtog[3];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_req_ready", req_ready, 1'b0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_rsp(8, 50);

        // Reset while DTX is stalled: transaction abandoned, toggles and rsp_data cleared.
        push_tx(P_OUT, 0, 4, 1, 0);
        send_req(0, 4, 1, 64'hCAFE);
        wait_tx(35, 50);
        tx_ready = 1'b0;
        @(negedge clk);
        check("dtx_tx_valid", tx_valid, 1'b1);
        check("dtx_tx_pid", tx_pid, dpid(mtog[1]));
        @(posedge clk); #1 rst_L = 1'b0;
        #1;
        check("arst_tx_valid", tx_valid, 1'b0);
        check("arst_req_ready", req_ready, 1'b1);
        @(posedge clk); #1 rst_L = 1'b1; tx_ready = 1'b1;
        mtog = 16'd0;
        m_rsp = 64'd0;
        repeat (5) @(negedge clk);
        check("arst_no_rsp", rsp_valid, 1'b0);
        @(posedge clk); #1;
        push_tx(P_OUT, 0, 4, 3, 0);
        push_tx(dpid(mtog[3]), 1, 4, 3, 64'h88);
        push_rsp(1, m_rsp);
        send_req(0, 4, 3, 64'h88);
        wait_tx(37, 50);
        send_rx(P_ACK, 0, 0);
        mtog[3] = ~mtog[3];
        wait_rsp(9, 50);

        // toggle_clr returns endp 3 to DATA0.
        toggle_clr = 1'b1;
        @(posedge clk); #1 toggle_clr = 1'b0;
        mtog = 16'd0;
        push_tx(P_OUT, 0, 4, 3, 0);
        push_tx(dpid(mtog[3]), 1, 4, 3, 64'h99);
        push_rsp(1, m_rsp);
        send_req(0, 4, 3, 64'h99);
        wait_tx(39, 50);
        send_rx(P_ACK, 0, 0);
        wait_rsp(10, 50);

        repeat (3) @(posedge clk);
        #1;
        check("tx_queue_drained", exp_tx.size(), 0);
        check("rsp_queue_drained", exp_rsp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
